vreg_scheduler: RTL and testbench

Round-robin scheduler that shares one `vregister` instance, with its LOAD/INCR/DECR control port, among `NREQ` requesters. Each requester offers one command per valid/ready handshake. The scheduler grants at most one command per cycle and drives the register's `ctrl`/`data_in` from a registered output stage. A shadow copy of the register value is kept for status and for the optional saturation feature. It sits between the requester logic and the register, and is the only driver of the register's control inputs.

---
 rtl/vreg_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/vregister.sv | 36 +++
 rtl/vreg_scheduler.sv | 153 +++++++++++++++
 tb/tb_vreg_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vreg_pkg.sv
// Shared definitions for the vregister control port.
// Holds the LOAD/INCR/DECR command encoding and its width. The register and
// the scheduler both use these constants, so their encodings always agree.
package vreg_pkg;

  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_NONE = 2'd0;
  localparam logic [CMD_W-1:0] CMD_LOAD = 2'd1;
  localparam logic [CMD_W-1:0] CMD_INCR = 2'd2;
  localparam logic [CMD_W-1:0] CMD_DECR = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// The scan starts at last_grant+1 (mod N) and moves upward. The first
// requester that is asserted gets the grant. last_grant changes only when
// `advance` is high, so an unaccepted grant keeps the same priority order.
// Ports:
//   clk          clock, rising edge
//   async_nreset asynchronous active-low reset; last_grant resets to N-1
//   req          request vector
//   advance      a grant was consumed this cycle
//   grant        one-hot grant (combinational)
//   grant_idx    index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          async_nreset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(last_grant) + 1 + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      last_grant <= IW'(N - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/vregister.sv
// Register with a LOAD/INCR/DECR control port.
// INCR and DECR wrap modulo 2^WIDTH. NONE holds the current value.
// Ports:
//   clk          clock, rising edge
//   async_nreset asynchronous active-low reset; clears the value to 0
//   ctrl         command (vreg_pkg encoding)
//   data_in      LOAD operand
//   data_out     current register value
module vregister
  import vreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic [CMD_W-1:0] ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      data_out <= '0;
    end else begin
      case (ctrl)
        CMD_LOAD: data_out <= data_in;
        CMD_INCR: data_out <= data_out + ONE;
        CMD_DECR: data_out <= data_out - ONE;
        default:  data_out <= data_out;
      endcase
    end
  end

endmodule

// File: rtl/vreg_scheduler.sv
// Round-robin scheduler that shares one vregister among NREQ requesters.
// Each cycle it grants at most one valid/ready command. The granted command
// and its operand are registered onto reg_ctrl/reg_data. A shadow copy of the
// register value follows the same update rules, so it tracks the register.
// Optional feature, enabled by defining VREG_SCHED_SAT_EN:
//   An INCR at all ones, or a DECR at zero, is issued as NONE.
//   sat_drop pulses for that cycle.
//   Without the macro, values wrap and sat_drop is tied low.
// Ports:
//   clk, async_nreset  clock (rising edge) and asynchronous active-low reset
//   req_valid[i]       requester i has a command pending
//   req_cmd            command of requester i at [2i+1:2i]
//   req_data           LOAD operand of requester i at [WIDTH*i +: WIDTH]
//   req_ready          one-hot grant; a transfer is req_valid[i] & req_ready[i]
//   reg_ctrl/reg_data  drive the register's ctrl/data_in
//   shadow_value       register value after all issued commands
//   sat_drop           the command issued this cycle was suppressed
module vreg_scheduler
  import vreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [CMD_W*NREQ-1:0] req_cmd,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [CMD_W-1:0]      reg_ctrl,
  output logic [WIDTH-1:0]      reg_data,
  output logic [WIDTH-1:0]      shadow_value,
  output logic                  sat_drop
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] apply_cmd(input logic [WIDTH-1:0] cur,
                                                 input logic [CMD_W-1:0] cmd,
                                                 input logic [WIDTH-1:0] opnd);
    case (cmd)
      CMD_LOAD: return opnd;
      CMD_INCR: return cur + ONE;
      CMD_DECR: return cur - ONE;
      default:  return cur;
    endcase
  endfunction

`ifdef VREG_SCHED_SAT_EN
  function automatic logic sat_hit(input logic [WIDTH-1:0] cur,
                                   input logic [CMD_W-1:0] cmd);
    return ((cmd == CMD_INCR) && (cur == '1)) ||
           ((cmd == CMD_DECR) && (cur == '0));
  endfunction
`endif

  // Stage 0: arbitration and command select (combinational)
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             xfer_p0;
  logic [CMD_W-1:0] cmd_p0;
  logic [CMD_W-1:0] ctrl_p0;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] shadow_nxt;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk          (clk),
    .async_nreset (async_nreset),
    .req          (req_valid),
    .advance      (xfer_p0),
    .grant        (grant),
    .grant_idx    (grant_idx)
  );

  // The arbiter grants only valid requesters. Gating with reset keeps
  // req_ready low while reset is asserted.
  assign req_ready = grant & {NREQ{async_nreset}};
  assign xfer_p0   = |(req_valid & req_ready);

  always_comb begin
    cmd_p0  = CMD_NONE;
    data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        cmd_p0  = req_cmd[CMD_W*i +: CMD_W];
        data_p0 = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // The value the register will hold after the command now on reg_ctrl.
  // The saturation check uses this value, so it already includes the
  // command issued in the previous cycle.
  assign shadow_nxt = apply_cmd(shadow_value, reg_ctrl, reg_data);

`ifdef VREG_SCHED_SAT_EN
  logic drop_p0;
  logic drop_p1;

  assign drop_p0  = sat_hit(shadow_nxt, cmd_p0);
  assign ctrl_p0  = drop_p0 ? CMD_NONE : cmd_p0;
  assign sat_drop = drop_p1;
`else
  assign ctrl_p0  = cmd_p0;
  assign sat_drop = 1'b0;
`endif

  // Stage 1: registered output to the register's control port
  logic [CMD_W-1:0] ctrl_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      ctrl_p1 <= CMD_NONE;
      data_p1 <= '0;
    end else if (xfer_p0) begin
      ctrl_p1 <= ctrl_p0;
      data_p1 <= data_p0;
    end else begin
      ctrl_p1 <= CMD_NONE;
    end
  end

`ifdef VREG_SCHED_SAT_EN
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      drop_p1 <= 1'b0;
    end else begin
      drop_p1 <= xfer_p0 & drop_p0;
    end
  end
`endif

  assign reg_ctrl = ctrl_p1;
  assign reg_data = data_p1;

  // Stage 2: shadow, updated on the same edge as the register
  logic [WIDTH-1:0] shadow_p2;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      shadow_p2 <= '0;
    end else begin
      shadow_p2 <= shadow_nxt;
    end
  end

  assign shadow_value = shadow_p2;

endmodule

// File: tb/tb_vreg_scheduler.sv
// Scoreboard testbench for vreg_scheduler driving a vregister.
module tb_vreg_scheduler;
  import vreg_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  async_nreset;
  logic [NREQ-1:0]       req_valid;
  logic [CMD_W*NREQ-1:0] req_cmd;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [CMD_W-1:0]      reg_ctrl;
  logic [WIDTH-1:0]      reg_data;
  logic [WIDTH-1:0]      shadow_value;
  logic                  sat_drop;
  logic [WIDTH-1:0]      reg_q;

  vreg_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .reg_ctrl     (reg_ctrl),
    .reg_data     (reg_data),
    .shadow_value (shadow_value),
    .sat_drop     (sat_drop)
  );

  vregister #(.WIDTH(WIDTH)) u_reg (
    .clk          (clk),
    .async_nreset (async_nreset),
    .ctrl         (reg_ctrl),
    .data_in      (reg_data),
    .data_out     (reg_q)
  );

  typedef struct {
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       sat;
    logic [7:0] shadow;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  logic xfer_prev;
  logic shadow_pending;
  logic [7:0] shadow_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of requests at posedge+1, check the grant at negedge and
  // queue the expected issued command when a grant is expected.
  task automatic step(input logic [3:0] v, input logic [7:0] cmds, input logic [31:0] data,
                      input logic [3:0] erdy, input logic [1:0] ectrl, input logic [7:0] edata,
                      input logic esat, input logic [7:0] eshadow);
    exp_t e;
    req_valid = v;
    req_cmd   = cmds;
    req_data  = data;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(erdy));
    if (erdy != 4'b0) begin
      e.ctrl = ectrl; e.data = edata; e.sat = esat; e.shadow = eshadow;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 8'h00, 32'h0, 4'h0, 2'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    req_valid      = 4'h0;
    async_nreset   = 1'b0;
    sb.delete();
    xfer_prev      = 1'b0;
    shadow_pending = 1'b0;
    #2;
    async_nreset   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    n_checks = 0; n_fail = 0;
    xfer_prev = 1'b0; shadow_pending = 1'b0; shadow_exp = 8'h00;
    async_nreset = 1'b0;
    req_valid = 4'hF; req_cmd = '0; req_data = '0;
    fork
      begin : stim
        #12;
        chk("rst_ctrl", 32'(reg_ctrl), 32'd0);
        chk("rst_data", 32'(reg_data), 32'd0);
        chk("rst_shadow", 32'(shadow_value), 32'd0);
        chk("rst_sat", 32'(sat_drop), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        @(posedge clk);
        #1;
        async_nreset = 1'b1;

        // requester 2 LOAD 0x5A
        step(4'b0100, 8'h10, 32'h005A0000, 4'b0100, CMD_LOAD, 8'h5A, 1'b0, 8'h5A);
        idle(2);

        // all four INCR for 8 cycles from a fresh reset
        apply_reset();
        step(4'hF, 8'hAA, 32'h13121110, 4'b0001, CMD_INCR, 8'h10, 1'b0, 8'h01);
        step(4'hF, 8'hAA, 32'h13121110, 4'b0010, CMD_INCR, 8'h11, 1'b0, 8'h02);
        step(4'hF, 8'hAA, 32'h13121110, 4'b0100, CMD_INCR, 8'h12, 1'b0, 8'h03);
        step(4'hF, 8'hAA, 32'h13121110, 4'b1000, CMD_INCR, 8'h13, 1'b0, 8'h04);
        step(4'hF, 8'hAA, 32'h13121110, 4'b0001, CMD_INCR, 8'h10, 1'b0, 8'h05);
        step(4'hF, 8'hAA, 32'h13121110, 4'b0010, CMD_INCR, 8'h11, 1'b0, 8'h06);
        step(4'hF, 8'hAA, 32'h13121110, 4'b0100, CMD_INCR, 8'h12, 1'b0, 8'h07);
        step(4'hF, 8'hAA, 32'h13121110, 4'b1000, CMD_INCR, 8'h13, 1'b0, 8'h08);
        idle(1);

        // requester 1 holds LOAD 0x10, requester 3 toggles INCR
        step(4'b1010, 8'h84, 32'h33001000, 4'b0010, CMD_LOAD, 8'h10, 1'b0, 8'h10);
        step(4'b0010, 8'h84, 32'h33001000, 4'b0010, CMD_LOAD, 8'h10, 1'b0, 8'h10);
        step(4'b1010, 8'h84, 32'h33001000, 4'b1000, CMD_INCR, 8'h33, 1'b0, 8'h11);
        step(4'b0010, 8'h84, 32'h33001000, 4'b0010, CMD_LOAD, 8'h10, 1'b0, 8'h10);
        step(4'b1010, 8'h84, 32'h33001000, 4'b1000, CMD_INCR, 8'h33, 1'b0, 8'h11);
        step(4'b1010, 8'h84, 32'h33001000, 4'b0010, CMD_LOAD, 8'h10, 1'b0, 8'h10);
        step(4'b1010, 8'h84, 32'h33001000, 4'b1000, CMD_INCR, 8'h33, 1'b0, 8'h11);
        idle(1);

        // LOAD 0xFF, INCR, DECR back-to-back
        step(4'b0001, 8'h01, 32'h000000FF, 4'b0001, CMD_LOAD, 8'hFF, 1'b0, 8'hFF);
`ifdef VREG_SCHED_SAT_EN
        step(4'b0001, 8'h02, 32'h00000000, 4'b0001, CMD_NONE, 8'h00, 1'b1, 8'hFF);
        step(4'b0001, 8'h03, 32'h00000000, 4'b0001, CMD_DECR, 8'h00, 1'b0, 8'hFE);
`else
        step(4'b0001, 8'h02, 32'h00000000, 4'b0001, CMD_INCR, 8'h00, 1'b0, 8'h00);
        step(4'b0001, 8'h03, 32'h00000000, 4'b0001, CMD_DECR, 8'h00, 1'b0, 8'hFF);
`endif

        // LOAD 0x00, INCR, DECR, DECR back-to-back
        step(4'b0001, 8'h01, 32'h00000000, 4'b0001, CMD_LOAD, 8'h00, 1'b0, 8'h00);
        step(4'b0001, 8'h02, 32'h00000000, 4'b0001, CMD_INCR, 8'h00, 1'b0, 8'h01);
        step(4'b0001, 8'h03, 32'h00000000, 4'b0001, CMD_DECR, 8'h00, 1'b0, 8'h00);
`ifdef VREG_SCHED_SAT_EN
        step(4'b0001, 8'h03, 32'h00000000, 4'b0001, CMD_NONE, 8'h00, 1'b1, 8'h00);
`else
        step(4'b0001, 8'h03, 32'h00000000, 4'b0001, CMD_DECR, 8'h00, 1'b0, 8'hFF);
`endif
        idle(2);

        // reset while a LOAD sits in the output stage
        step(4'b0100, 8'h10, 32'h00A50000, 4'b0100, CMD_LOAD, 8'hA5, 1'b0, 8'hA5);
        chk("mid_ctrl_before", 32'(reg_ctrl), 32'(CMD_LOAD));
        req_valid      = 4'hF;
        async_nreset   = 1'b0;
        sb.delete();
        xfer_prev      = 1'b0;
        shadow_pending = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'(reg_ctrl), 32'd0);
        chk("mid_rst_data", 32'(reg_data), 32'd0);
        chk("mid_rst_shadow", 32'(shadow_value), 32'd0);
        chk("mid_rst_reg", 32'(reg_q), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        #1;
        async_nreset = 1'b1;
        // NONE commands still handshake; requester 0 has priority first
        step(4'hF, 8'h00, 32'h00006677, 4'b0001, CMD_NONE, 8'h77, 1'b0, 8'h00);
        step(4'hF, 8'h00, 32'h00006677, 4'b0010, CMD_NONE, 8'h66, 1'b0, 8'h00);
        idle(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (shadow_pending) begin
            chk("shadow", 32'(shadow_value), 32'(shadow_exp));
            shadow_pending = 1'b0;
          end
          if (xfer_prev) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("reg_ctrl", 32'(reg_ctrl), 32'(e.ctrl));
              chk("reg_data", 32'(reg_data), 32'(e.data));
              chk("sat_drop", 32'(sat_drop), 32'(e.sat));
              shadow_exp     = e.shadow;
              shadow_pending = 1'b1;
            end
          end
          chk("shadow_vs_reg", 32'(shadow_value), 32'(reg_q));
          xfer_prev = async_nreset && (|(req_valid & req_ready));
        end
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
